// File: rtl/pipe_hazard_if.sv
// Hazard-unit bundle between the ID stage and the pipe_hazard_scoreboard.
// The master side drives the ID-side request signals.
// The slave side (the scoreboard) returns the control and counter outputs.
interface pipe_hazard_if #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned REG_AW = 5
);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              ex_redirect;

    logic              stall;
    logic              flush_ifid;
    logic              bubble_idex;
    logic [FW-1:0]     fwd_rs1;
    logic [FW-1:0]     fwd_rs2;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_redirect,
        input  stall, flush_ifid, bubble_idex, fwd_rs1, fwd_rs2,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_redirect,
        output stall, flush_ifid, bubble_idex, fwd_rs1, fwd_rs2,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Pipeline hazard scoreboard.
// It tracks the instructions in the DEPTH stages after ID.
// From these it produces forwarding selects, the load-use stall, the redirect flush and bubble controls.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
// Without that macro, stall_cnt and flush_cnt are tied to zero.
module pipe_hazard_scoreboard #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  hz
);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } sb_entry_t;

    sb_entry_t     sb [1:DEPTH];

    logic [FW-1:0] sel_rs1;
    logic [FW-1:0] sel_rs2;
    logic          load_rs1;
    logic          load_rs2;
    logic          hazard;
    logic          stall_w;

    // Producer search: scan oldest to youngest so the youngest match wins
    always_comb begin
        sel_rs1  = '0;
        sel_rs2  = '0;
        load_rs1 = 1'b0;
        load_rs2 = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hz.id_valid && sb[k].valid && sb[k].regwrite &&
                hz.id_use_rs1 && (hz.id_rs1 != '0) && (sb[k].rd == hz.id_rs1)) begin
                sel_rs1  = FW'(k);
                load_rs1 = sb[k].is_load;
            end
            if (hz.id_valid && sb[k].valid && sb[k].regwrite &&
                hz.id_use_rs2 && (hz.id_rs2 != '0) && (sb[k].rd == hz.id_rs2)) begin
                sel_rs2  = FW'(k);
                load_rs2 = sb[k].is_load;
            end
        end
    end

    // Load data not yet forwardable stalls ID; a redirect overrides the stall
    always_comb begin
        hazard  = (load_rs1 && (sel_rs1 != '0) && (sel_rs1 < FW'(LOAD_LAT))) ||
                  (load_rs2 && (sel_rs2 != '0) && (sel_rs2 < FW'(LOAD_LAT)));
        stall_w = hazard && !hz.ex_redirect;
    end

    assign hz.stall       = stall_w;
    assign hz.flush_ifid  = hz.ex_redirect;
    assign hz.bubble_idex = stall_w || hz.ex_redirect;
    assign hz.fwd_rs1     = sel_rs1;
    assign hz.fwd_rs2     = sel_rs2;

    // Scoreboard shift; entry 1 takes the ID instruction only when it advances
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = 2; k <= DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
            if (hz.id_valid && !stall_w && !hz.ex_redirect) begin
                sb[1].valid    <= 1'b1;
                sb[1].rd       <= hz.id_rd;
                sb[1].regwrite <= hz.id_regwrite;
                sb[1].is_load  <= hz.id_is_load;
            end else begin
                sb[1] <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating stall and redirect cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.ex_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed self-checking bench for pipe_hazard_scoreboard (DEPTH=3, REG_AW=5, LOAD_LAT=2).
// When PIPE_PERF_CNT_EN is defined, the expected counter values are the real stall and redirect counts.
// Otherwise the expected counter values are zero.
module tb_pipe_hazard_scoreboard;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;

    pipe_hazard_if #(.DEPTH(3), .REG_AW(5)) hif ();

    pipe_hazard_scoreboard #(
        .DEPTH    (3),
        .REG_AW   (5),
        .LOAD_LAT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        hif.id_valid    = v;
        hif.id_rs1      = rs1;
        hif.id_use_rs1  = u1;
        hif.id_rs2      = rs2;
        hif.id_use_rs2  = u2;
        hif.id_rd       = rd;
        hif.id_regwrite = rw;
        hif.id_is_load  = ld;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        hif.ex_redirect = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_stall", 32'(hif.stall), 32'd0);
        chk("rst_fwd1", 32'(hif.fwd_rs1), 32'd0);
        chk("rst_fwd2", 32'(hif.fwd_rs2), 32'd0);
        chk("rst_flush", 32'(hif.flush_ifid), 32'd0);
        chk("rst_bubble", 32'(hif.bubble_idex), 32'd0);
        chk("rst_scnt", hif.stall_cnt, 32'd0);
        chk("rst_fcnt", hif.flush_cnt, 32'd0);

        // ALU forwarding: x5 writer at k=1, then k=2
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("alu_fwd1_k1", 32'(hif.fwd_rs1), 32'd1);
        chk("alu_stall", 32'(hif.stall), 32'd0);
        chk("alu_bubble", 32'(hif.bubble_idex), 32'd0);
        step();
        chk("alu_fwd1_k2", 32'(hif.fwd_rs1), 32'd2);
        drain();

        // Load-use: three stall cycles in total
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
            step();
            set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
            chk("lu_stall", 32'(hif.stall), 32'd1);
            chk("lu_bubble", 32'(hif.bubble_idex), 32'd1);
            chk("lu_flush", 32'(hif.flush_ifid), 32'd0);
            step();
            chk("lu_next_stall", 32'(hif.stall), 32'd0);
            chk("lu_next_fwd2", 32'(hif.fwd_rs2), 32'd2);
            step();
            drain();
        end

        // x0 never matches, neither ALU nor load writer
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("x0_fwd1", 32'(hif.fwd_rs1), 32'd0);
        chk("x0_stall", 32'(hif.stall), 32'd0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("x0_load_stall", 32'(hif.stall), 32'd0);
        chk("x0_load_fwd1", 32'(hif.fwd_rs1), 32'd0);
        drain();

        // Youngest wins: x3 writers at k=3 and k=1
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("yw_fwd1", 32'(hif.fwd_rs1), 32'd1);
        chk("yw_fwd2", 32'(hif.fwd_rs2), 32'd1);
        set_id(1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("yw_nouse_fwd1", 32'(hif.fwd_rs1), 32'd0);
        drain();

        // Redirect beats a load-use stall; the ID instruction is squashed
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        hif.ex_redirect = 1'b1;
        #1;
        chk("rd_stall", 32'(hif.stall), 32'd0);
        chk("rd_flush", 32'(hif.flush_ifid), 32'd1);
        chk("rd_bubble", 32'(hif.bubble_idex), 32'd1);
        step();
        hif.ex_redirect = 1'b0;
        #1;
        chk("rd_next_fwd1", 32'(hif.fwd_rs1), 32'd2);
        chk("rd_next_stall", 32'(hif.stall), 32'd0);
        chk("rd_next_flush", 32'(hif.flush_ifid), 32'd0);
        drain();

        // No stall when ID is empty
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        step();
        set_id(1'b0, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("idle_stall", 32'(hif.stall), 32'd0);
        chk("idle_fwd1", 32'(hif.fwd_rs1), 32'd0);
        drain();

        // Counters: 3 stall cycles, 1 redirect cycle
`ifdef PIPE_PERF_CNT_EN
        exp_stall_cnt = 32'd3;
        exp_flush_cnt = 32'd1;
`else
        exp_stall_cnt = 32'd0;
        exp_flush_cnt = 32'd0;
`endif
        chk("cnt_stall", hif.stall_cnt, exp_stall_cnt);
        chk("cnt_flush", hif.flush_cnt, exp_flush_cnt);

        // Reset during a stall leaves no residual stall and clears counters
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("mr_stall_before", 32'(hif.stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_stall_after", 32'(hif.stall), 32'd0);
        chk("mr_bubble_after", 32'(hif.bubble_idex), 32'd0);
        chk("mr_fwd1_after", 32'(hif.fwd_rs1), 32'd0);
        chk("mr_scnt", hif.stall_cnt, 32'd0);
        chk("mr_fcnt", hif.flush_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
